// File: rtl/store_queue_pkg.sv
// ============================================================================
// Module : store_queue_pkg
// Brief  : Shared entry layout and pointer-width helpers for the store queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package store_queue_pkg;

    localparam int c_sq_xlen  = 32;
    localparam int c_sq_tag_w = 5;

    // Reference layout; modules rebuild it locally with their own widths.
    typedef struct packed {
        logic                  valid;
        logic [c_sq_tag_w-1:0] rob_tag;
        logic [c_sq_xlen-1:0]  addr;
        logic                  addr_ok;
        logic [c_sq_xlen-1:0]  data;
        logic                  data_ok;
        logic                  committed;
    } sq_entry_t;

    // Pointers carry one extra wrap bit above the slot index.
    function automatic int sq_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int sq_idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/store_queue_forward_select.sv
// ============================================================================
// Module : store_queue_forward_select
// Brief  : Picks the youngest matching entry, walking slots in age order.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module store_queue_forward_select
    import store_queue_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]           i_match,
    input  logic [DEPTH-1:0][XLEN-1:0] i_data,
    input  logic [sq_idx_w(DEPTH)-1:0] i_head_idx,
    output logic                       o_hit,
    output logic [XLEN-1:0]            o_data
);

    localparam int c_idx_w = sq_idx_w(DEPTH);

    logic [c_idx_w-1:0] w_idx;

    // Valid entries are contiguous from head, so the last match seen is youngest.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head_idx + c_idx_w'(k);
            if (i_match[w_idx]) begin
                o_hit  = 1'b1;
                o_data = i_data[w_idx];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/store_queue.sv
// ============================================================================
// Module : store_queue
// Brief  : Program-ordered store buffer draining committed stores to memory.
//          Define STORE_QUEUE_FORWARD_EN to add store-to-load forwarding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module store_queue
    import store_queue_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int ROB_TAG_WIDTH = 5,
    parameter int DEPTH         = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     alloc_valid,
    input  logic [ROB_TAG_WIDTH-1:0] alloc_rob_tag,
    output logic                     alloc_ready,
    input  logic                     addr_valid,
    input  logic [ROB_TAG_WIDTH-1:0] addr_rob_tag,
    input  logic [XLEN-1:0]          addr,
    input  logic                     data_valid,
    input  logic [ROB_TAG_WIDTH-1:0] data_rob_tag,
    input  logic [XLEN-1:0]          data,
    input  logic                     commit_valid,
    input  logic [ROB_TAG_WIDTH-1:0] commit_rob_tag,
    input  logic                     flush,
    output logic                     mem_req_valid,
    output logic [XLEN-1:0]          mem_req_addr,
    output logic [XLEN-1:0]          mem_req_data,
    input  logic                     mem_req_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
`ifdef STORE_QUEUE_FORWARD_EN
    ,
    input  logic [XLEN-1:0]          lookup_addr,
    output logic                     lookup_hit,
    output logic [XLEN-1:0]          lookup_data
`endif
);

    localparam int c_ptr_w = sq_ptr_w(DEPTH);
    localparam int c_idx_w = sq_idx_w(DEPTH);

    typedef struct packed {
        logic                     valid;
        logic [ROB_TAG_WIDTH-1:0] rob_tag;
        logic [XLEN-1:0]          addr;
        logic                     addr_ok;
        logic [XLEN-1:0]          data;
        logic                     data_ok;
        logic                     committed;
    } entry_t;

    entry_t             r_entry [DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;

    logic [c_idx_w-1:0] w_head_idx;
    logic [c_idx_w-1:0] w_tail_idx;
    logic               w_full;
    logic               w_alloc;
    logic               w_pop;
    logic [DEPTH-1:0]   w_addr_hit;
    logic [DEPTH-1:0]   w_data_hit;
    logic [DEPTH-1:0]   w_cmt_hit;
    logic [DEPTH-1:0]   w_keep;
    logic [c_ptr_w-1:0] w_ncmt;

    assign w_head_idx = r_head[c_idx_w-1:0];
    assign w_tail_idx = r_tail[c_idx_w-1:0];
    assign w_full     = (w_head_idx == w_tail_idx) && (r_head[c_ptr_w-1] != r_tail[c_ptr_w-1]);
    assign alloc_ready = !w_full;
    assign w_alloc    = alloc_valid && alloc_ready && !flush;

    assign mem_req_valid = r_entry[w_head_idx].valid && r_entry[w_head_idx].committed &&
                           r_entry[w_head_idx].addr_ok && r_entry[w_head_idx].data_ok;
    assign mem_req_addr  = r_entry[w_head_idx].addr;
    assign mem_req_data  = r_entry[w_head_idx].data;
    assign w_pop         = mem_req_valid && mem_req_ready;

    assign count = r_tail - r_head;
    assign empty = (count == '0);

    // A same-cycle commit counts as committed, so it survives a flush.
    always_comb begin
        w_addr_hit = '0;
        w_data_hit = '0;
        w_cmt_hit  = '0;
        w_keep     = '0;
        w_ncmt     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_addr_hit[i] = addr_valid && r_entry[i].valid && (r_entry[i].rob_tag == addr_rob_tag);
            w_data_hit[i] = data_valid && r_entry[i].valid && (r_entry[i].rob_tag == data_rob_tag);
            w_cmt_hit[i]  = commit_valid && r_entry[i].valid && (r_entry[i].rob_tag == commit_rob_tag);
            w_keep[i]     = r_entry[i].valid && (r_entry[i].committed || w_cmt_hit[i]);
            if (w_keep[i]) begin
                w_ncmt = w_ncmt + c_ptr_w'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_head <= '0;
            r_tail <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush && !w_keep[i]) begin
                    r_entry[i] <= '0;
                end else if (w_pop && (c_idx_w'(i) == w_head_idx)) begin
                    r_entry[i] <= '0;
                end else if (w_alloc && (c_idx_w'(i) == w_tail_idx)) begin
                    r_entry[i]         <= '0;
                    r_entry[i].valid   <= 1'b1;
                    r_entry[i].rob_tag <= alloc_rob_tag;
                end else begin
                    if (w_addr_hit[i]) begin
                        r_entry[i].addr    <= addr;
                        r_entry[i].addr_ok <= 1'b1;
                    end
                    if (w_data_hit[i]) begin
                        r_entry[i].data    <= data;
                        r_entry[i].data_ok <= 1'b1;
                    end
                    if (w_cmt_hit[i]) begin
                        r_entry[i].committed <= 1'b1;
                    end
                end
            end

            if (w_pop) begin
                r_head <= r_head + c_ptr_w'(1);
            end

            // Committed entries run contiguously from head, so they end at head + w_ncmt.
            if (flush) begin
                r_tail <= r_head + w_ncmt;
            end else if (w_alloc) begin
                r_tail <= r_tail + c_ptr_w'(1);
            end
        end
    end

`ifdef STORE_QUEUE_FORWARD_EN
    logic [DEPTH-1:0]           w_fwd_match;
    logic [DEPTH-1:0][XLEN-1:0] w_fwd_data;

    always_comb begin
        w_fwd_match = '0;
        w_fwd_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_fwd_match[i] = r_entry[i].valid && r_entry[i].addr_ok && r_entry[i].data_ok &&
                             (r_entry[i].addr == lookup_addr);
            w_fwd_data[i]  = r_entry[i].data;
        end
    end

    store_queue_forward_select #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fwd_select (
        .i_match    (w_fwd_match),
        .i_data     (w_fwd_data),
        .i_head_idx (w_head_idx),
        .o_hit      (lookup_hit),
        .o_data     (lookup_data)
    );
`endif

endmodule

`default_nettype wire
